// File: rtl/uart_rx_if.sv
// Receive-side valid/ready handshake between uart_rx and its consumer.
// master = uart_rx (producer), slave = downstream consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, centre-sampled, valid/ready output.
// Optional parity bit (parity_odd / parity_err) enabled by UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      baud_en,
    input  logic      rx,
`ifdef UART_RX_PARITY_EN
    input  logic      parity_odd,
    output logic      parity_err,
`endif
    uart_rx_if.master bus,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK_WAIT
    } state_t;
`endif

    state_t               state;
    state_t               nxt;
    logic                 sync1;
    logic                 rxs;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 mid;
    logic                 fin;
    logic                 load;
    logic                 bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    assign mid = baud_en && (tick == T_MID);
    assign fin = baud_en && (tick == T_END);

    // Synchronizer presets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (baud_en && !rxs) nxt = START;
            end
            START: begin
                if (mid) nxt = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (fin && bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                    nxt = PARITY;
`else
                    nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (fin) nxt = STOP;
            end
`endif
            STOP: begin
                if (fin) nxt = rxs ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (baud_en && rxs) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        load = (state == STOP) && fin && rxs;
        bad  = (state == STOP) && fin && !rxs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (baud_en) begin
            unique case (state)
                START: begin
                    tick    <= mid ? '0 : tick + 1'b1;
                    bit_cnt <= '0;
                end
                DATA: begin
                    tick <= fin ? '0 : tick + 1'b1;
                    if (fin) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick <= fin ? '0 : tick + 1'b1;
                    if (fin) par_bit <= rxs;
                end
`endif
                STOP: begin
                    tick <= fin ? '0 : tick + 1'b1;
                end
                default: tick <= '0;
            endcase
        end
    end

    // A completed word overwrites a pending one; acceptance in the same clk wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= bad;
            overrun   <= load && valid_q && !bus.rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= (load || bad) &&
                          (par_bit != ((^shreg) ^ parity_odd));
`endif
            if (load) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 at 16x oversample, baud_en every 4 clk.
// Build with UART_RX_PARITY_EN to add the parity frames.
module tb_uart_rx;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic baud_en = 1'b0;
    logic rx      = 1'b1;
    logic frame_err;
    logic overrun;
    logic busy;
`ifdef UART_RX_PARITY_EN
    logic parity_odd = 1'b0;
    logic parity_err;
    int   pe_cnt = 0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   rise_cnt = 0;
    int   lat_bad = 0;
    int   bcnt = 0;
    logic v_q = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) rif();

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_en   (baud_en),
        .rx        (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
        .parity_err(parity_err),
`endif
        .bus       (rif),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // baud_en here still holds the value seen at the posedge just passed
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
        if (rif.rx_valid && !v_q) begin
            rise_cnt++;
            if (!baud_en) lat_bad++;
        end
        v_q = rif.rx_valid;
        bcnt = (bcnt == 3) ? 0 : bcnt + 1;
        baud_en = (bcnt == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx = v[i];
            wait_clk(64);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p,
                              input logic stop);
`ifdef UART_RX_PARITY_EN
        send({5'b0, stop, p, b, 1'b0}, 11);
`else
        send({6'b0, stop, b, 1'b0}, 10);
`endif
    endtask

    task automatic accept(input string tag);
        rif.rx_ready = 1'b1;
        #1;
        chk({tag, "_hold"}, 32'(rif.rx_valid), 1);
        @(negedge clk);
        rif.rx_ready = 1'b0;
        chk({tag, "_clr"}, 32'(rif.rx_valid), 0);
    endtask

    initial begin
        rif.rx_ready = 1'b0;
        wait_clk(3);
        chk("rst_valid", 32'(rif.rx_valid), 0);
        chk("rst_data", 32'(rif.rx_data), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        wait_clk(20);

        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_valid", 32'(rif.rx_valid), 1);
        chk("a5_data", 32'(rif.rx_data), 32'hA5);
        chk("a5_ferr", 32'(fe_cnt), 0);
        chk("a5_ovr", 32'(ov_cnt), 0);
        accept("a5");

        chk("gl_idle", 32'(busy), 0);
        rx = 1'b0;
        wait_clk(12);
        chk("gl_busy", 32'(busy), 1);
        wait_clk(12);
        rx = 1'b1;
        wait_clk(64);
        chk("gl_done", 32'(busy), 0);
        chk("gl_valid", 32'(rif.rx_valid), 0);
        chk("gl_ferr", 32'(fe_cnt), 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(3 * 64);
        rx = 1'b1;
        wait_clk(64);
        chk("brk_ferr", 32'(fe_cnt), 1);
        chk("brk_valid", 32'(rif.rx_valid), 0);
        chk("brk_busy", 32'(busy), 0);
        send_frame(8'h81, 1'b0, 1'b1);
        chk("x81_valid", 32'(rif.rx_valid), 1);
        chk("x81_data", 32'(rif.rx_data), 32'h81);
        chk("x81_ferr", 32'(fe_cnt), 1);
        accept("x81");

        send_frame(8'h11, 1'b0, 1'b1);
        chk("x11_valid", 32'(rif.rx_valid), 1);
        chk("x11_data", 32'(rif.rx_data), 32'h11);
        chk("x11_ovr", 32'(ov_cnt), 0);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("x22_ovr", 32'(ov_cnt), 1);
        chk("x22_valid", 32'(rif.rx_valid), 1);
        chk("x22_data", 32'(rif.rx_data), 32'h22);
        accept("x22");

        send(16'h001E, 5);
        wait_clk(32);
        chk("pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_valid", 32'(rif.rx_valid), 0);
        chk("ar_data", 32'(rif.rx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(32 + 6 * 64);
        chk("ar_quiet", 32'(rif.rx_valid), 0);
        chk("ar_ferr", 32'(fe_cnt), 1);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("x5a_valid", 32'(rif.rx_valid), 1);
        chk("x5a_data", 32'(rif.rx_data), 32'h5A);
        accept("x5a");

`ifdef UART_RX_PARITY_EN
        chk("par_clean", 32'(pe_cnt), 0);
        send_frame(8'h07, 1'b0, 1'b1);
        chk("p0_perr", 32'(pe_cnt), 1);
        chk("p0_valid", 32'(rif.rx_valid), 1);
        chk("p0_data", 32'(rif.rx_data), 32'h07);
        accept("p0");
        send_frame(8'h07, 1'b1, 1'b1);
        chk("p1_perr", 32'(pe_cnt), 1);
        chk("p1_valid", 32'(rif.rx_valid), 1);
        chk("p1_data", 32'(rif.rx_data), 32'h07);
        accept("p1");
        chk("rises", 32'(rise_cnt), 6);
`else
        chk("rises", 32'(rise_cnt), 4);
`endif
        chk("latency", 32'(lat_bad), 0);
        chk("ovr_total", 32'(ov_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
